// File: rtl/sram_ctrl.sv
// Burst master for a single-port SRAM: takes valid/ready burst requests and issues one word per
// cycle with an auto-incrementing address. Read beats come back as single-cycle response pulses.
module sram_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              res,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              done,
  output logic              busy,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWrite = 3'd1;
  localparam logic [2:0] StRead  = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              sram_we_q, sram_we_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_din_q, sram_din_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              done_q, done_d;
  // Bit i set: a read address became visible on sram_addr i cycles ago. Top bit is rsp_valid.
  logic [RD_LAT:0]   pipe_q, pipe_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    sram_we_d   = 1'b0;
    sram_addr_d = sram_addr_q;
    sram_din_d  = sram_din_q;
    rsp_rdata_d = rsp_rdata_q;
    done_d      = 1'b0;
    pipe_d      = {pipe_q[RD_LAT-1:0], 1'b0};

    // The last pipe stage before the output is where sram_dout holds that beat's data.
    if (pipe_q[RD_LAT-1]) begin
      rsp_rdata_d = sram_dout;
    end

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_addr;
          cnt_d   = req_len;
          state_d = req_we ? StWrite : StRead;
        end
      end
      StWrite: begin
        if (wr_valid) begin
          sram_we_d   = 1'b1;
          sram_addr_d = addr_q;
          sram_din_d  = wr_data;
          addr_d      = addr_q + 1'b1;
          cnt_d       = cnt_q - 4'd1;
          if (cnt_q == 4'd0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      StRead: begin
        sram_addr_d = addr_q;
        pipe_d[0]   = 1'b1;
        addr_d      = addr_q + 1'b1;
        cnt_d       = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (pipe_q == '0) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      cnt_q       <= '0;
      sram_we_q   <= 1'b0;
      sram_addr_q <= '0;
      sram_din_q  <= '0;
      rsp_rdata_q <= '0;
      done_q      <= 1'b0;
      pipe_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      sram_we_q   <= sram_we_d;
      sram_addr_q <= sram_addr_d;
      sram_din_q  <= sram_din_d;
      rsp_rdata_q <= rsp_rdata_d;
      done_q      <= done_d;
      pipe_q      <= pipe_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign wr_ready  = (state_q == StWrite);
  assign busy      = (state_q != StIdle);
  assign sram_we   = sram_we_q;
  assign sram_addr = sram_addr_q;
  assign sram_din  = sram_din_q;
  assign rsp_valid = pipe_q[RD_LAT];
  assign rsp_rdata = rsp_rdata_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: single-word vector table plus burst, stall, wrap, reset and
// busy-request sequences against a behavioural SRAM with one-cycle read latency.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        res;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_addr;
  logic [3:0]  req_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        done, busy;
  logic        sram_we;
  logic [7:0]  sram_addr;
  logic [31:0] sram_din, sram_dout;

  always #5 clk = ~clk;

  sram_ctrl #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1)) dut (
    .clk(clk), .res(res),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .done(done), .busy(busy),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // RD_LAT = 1: data for the address on the bus is valid within the same cycle.
  logic [31:0] mem [256];
  always @(posedge clk) if (sram_we) mem[sram_addr] <= sram_din;
  assign sram_dout = mem[sram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  logic [31:0] rd_q[$];
  int          rc_q[$];
  int          done_n = 0;
  int          done_c = 0;

  always @(negedge clk) begin
    if (sram_we) begin
      wa_q.push_back(sram_addr);
      wd_q.push_back(sram_din);
      wc_q.push_back(cyc);
    end
    if (rsp_valid) begin
      rd_q.push_back(rsp_rdata);
      rc_q.push_back(cyc);
    end
    if (done) begin
      done_n++;
      done_c = cyc;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the falling edge, after the monitor has sampled.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); rd_q.delete(); rc_q.delete();
  endtask

  task automatic hshake(input logic we, input logic [7:0] a, input logic [3:0] l, output int hs);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = a; req_len = l;
    n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    chk("handshake_ready", {31'd0, req_ready}, 32'd1);
    hs = cyc;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_n == d0 && n < 200) begin
      tick();
      n++;
    end
    chk("done_seen", done_n - d0, 32'd1);
  endtask

  logic [31:0] wbuf [16];

  task automatic do_write(input logic [7:0] a, input logic [3:0] l, input int stall_after,
                          input int stall_n, output int hs);
    int d0;
    d0 = done_n;
    hshake(1'b1, a, l, hs);
    for (int b = 0; b <= int'(l); b++) begin
      wr_valid = 1'b1;
      wr_data  = wbuf[b];
      tick();
      if (b == stall_after) begin
        wr_valid = 1'b0;
        repeat (stall_n) tick();
      end
    end
    wr_valid = 1'b0;
    wait_done(d0);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [3:0] l, output int hs);
    int d0;
    d0 = done_n;
    hshake(1'b0, a, l, hs);
    wait_done(d0);
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hs, hs2, d0, viol;
    vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 8'h55, 32'h12345678, 32'h0};
    vecs[3] = '{1'b1, 8'h10, 32'hCAFEF00D, 32'h0};
    vecs[4] = '{1'b0, 8'h55, 32'h0,        32'h12345678};
    vecs[5] = '{1'b0, 8'h10, 32'h0,        32'hCAFEF00D};

    res = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    repeat (3) tick();
    chk("rst_sram_we", {31'd0, sram_we}, 32'd0);
    chk("rst_sram_addr", {24'd0, sram_addr}, 32'd0);
    res = 1'b0;
    tick();
    chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Single-word vectors
    for (int i = 0; i < 6; i++) begin
      clear_logs();
      if (vecs[i].we) begin
        wbuf[0] = vecs[i].wdata;
        do_write(vecs[i].addr, 4'd0, -1, 0, hs);
        chk($sformatf("v%0d_nwr", i), wa_q.size(), 32'd1);
        chk($sformatf("v%0d_waddr", i), {24'd0, wa_q[0]}, {24'd0, vecs[i].addr});
        chk($sformatf("v%0d_wdata", i), wd_q[0], vecs[i].wdata);
        chk($sformatf("v%0d_wcyc", i), wc_q[0], hs + 2);
      end else begin
        do_read(vecs[i].addr, 4'd0, hs);
        chk($sformatf("v%0d_nrsp", i), rd_q.size(), 32'd1);
        chk($sformatf("v%0d_rdata", i), rd_q[0], vecs[i].exp_rdata);
        chk($sformatf("v%0d_rlat", i), rc_q[0], hs + 3);
      end
    end

    // Burst write with a 2-cycle stall after beat 1, then read back
    clear_logs();
    wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h4; wbuf[3] = 32'h8;
    do_write(8'h00, 4'd3, 1, 2, hs);
    chk("bst_nwr", wa_q.size(), 32'd4);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("bst_waddr%0d", b), {24'd0, wa_q[b]}, b);
      chk($sformatf("bst_wdata%0d", b), wd_q[b], 32'd1 << b);
    end
    chk("bst_gap01", wc_q[1] - wc_q[0], 32'd1);
    chk("bst_gap12", wc_q[2] - wc_q[1], 32'd3);
    chk("bst_gap23", wc_q[3] - wc_q[2], 32'd1);
    clear_logs();
    do_read(8'h00, 4'd3, hs);
    chk("bst_nrsp", rd_q.size(), 32'd4);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("bst_rdata%0d", b), rd_q[b], 32'd1 << b);
      chk($sformatf("bst_rcyc%0d", b), rc_q[b], hs + 3 + b);
    end

    // Address wrap
    clear_logs();
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
    do_write(8'hFE, 4'd3, -1, 0, hs);
    chk("wrap_nwr", wa_q.size(), 32'd4);
    chk("wrap_a0", {24'd0, wa_q[0]}, 32'hFE);
    chk("wrap_a1", {24'd0, wa_q[1]}, 32'hFF);
    chk("wrap_a2", {24'd0, wa_q[2]}, 32'h00);
    chk("wrap_a3", {24'd0, wa_q[3]}, 32'h01);
    clear_logs();
    do_read(8'hFE, 4'd3, hs);
    chk("wrap_nrsp", rd_q.size(), 32'd4);
    for (int b = 0; b < 4; b++) chk($sformatf("wrap_rdata%0d", b), rd_q[b], 32'hA + b);

    // Reset in the middle of a 16-beat read
    for (int b = 0; b < 16; b++) wbuf[b] = 32'h2000 + b;
    do_write(8'h20, 4'd15, -1, 0, hs);
    clear_logs();
    d0 = done_n;
    hshake(1'b0, 8'h20, 4'd15, hs);
    for (int n = 0; n < 50 && rd_q.size() < 5; n++) tick();
    chk("rst_mid_got5", rd_q.size(), 32'd5);
    res = 1'b1;
    tick();
    chk("rst_mid_we", {31'd0, sram_we}, 32'd0);
    res = 1'b0;
    repeat (25) tick();
    chk("rst_mid_nrsp", rd_q.size(), 32'd5);
    chk("rst_mid_nodone", done_n - d0, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    for (int b = 0; b < 5; b++) chk($sformatf("rst_mid_rdata%0d", b), rd_q[b], 32'h2000 + b);
    clear_logs();
    do_read(8'h25, 4'd0, hs);
    chk("post_rst_nrsp", rd_q.size(), 32'd1);
    chk("post_rst_rdata", rd_q[0], 32'h2005);
    chk("post_rst_rlat", rc_q[0], hs + 3);

    // Request held during an 8-beat write
    clear_logs();
    d0 = done_n;
    viol = 0;
    hshake(1'b1, 8'h60, 4'd7, hs);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; req_len = 4'd0;
    for (int b = 0; b < 8; b++) begin
      if (req_ready) viol++;
      wr_valid = 1'b1;
      wr_data  = 32'h11111111 * b;
      tick();
    end
    wr_valid = 1'b0;
    for (int n = 0; n < 50 && done_n == d0; n++) begin
      if (req_ready) viol++;
      tick();
    end
    if (req_ready) viol++;
    chk("busy_req_ready_low", viol, 32'd0);
    chk("busy_done", done_n - d0, 32'd1);
    chk("busy_nwr", wa_q.size(), 32'd8);
    chk("busy_wlast", wd_q[7], 32'h77777777);
    tick();
    chk("busy_accept_ready", {31'd0, req_ready}, 32'd1);
    hs2 = cyc;
    chk("busy_accept_cyc", hs2, done_c + 1);
    tick();
    req_valid = 1'b0;
    d0 = done_n;
    wait_done(d0);
    chk("busy_nrsp", rd_q.size(), 32'd1);
    chk("busy_rdata", rd_q[0], 32'hCAFEF00D);
    chk("busy_rlat", rc_q[0], hs2 + 3);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
